// File: rtl/larpix_cfg_scheduler.sv
// Round-robin configuration scheduler: builds LArPix config packets for the FPGA UART,
// drives the load/busy handshake and matches config-read replies with a timeout.
module larpix_cfg_scheduler #(
    parameter int          NUM_REQ        = 4,
    parameter logic [31:0] MAGIC_NUMBER   = 32'h89504E47,
    parameter logic [7:0]  GLOBAL_ID      = 8'd255,
    parameter int          GAP_CYCLES     = 4,
    parameter int          TIMEOUT_CYCLES = 2000,
    localparam int         IDW            = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_rd,
    input  logic [8*NUM_REQ-1:0]   req_chip_id,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [63:0]            tx_data,
    output logic                   ld_tx_data,
    input  logic                   tx_busy,
    input  logic                   rx_valid,
    input  logic [63:0]            rx_data,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [7:0]             rsp_data,
    output logic                   rsp_timeout,
    output logic                   sched_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE, S_GAP, S_RD_WAIT
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d, cnt_inc;
    logic [IDW-1:0] ptr_q, ptr_d, win_q, win_d, ptr_inc;
    logic           rd_q, rd_d;
    logic [7:0]     chip_q, chip_d, addr_q, addr_d;
    logic [63:0]    tx_data_q, tx_data_d;

    logic [IDW-1:0] hi_idx, lo_idx, win_sel;
    logic           found_hi, found_lo;
    logic [IDW:0]   win_nxt;
    logic           rx_parity_ok, rx_match;

    // Bit 63 makes the total popcount of the 64-bit packet odd.
    function automatic logic [63:0] build_pkt(input logic rd, input logic [7:0] chip,
                                              input logic [7:0] addr, input logic [7:0] data);
        logic [62:0] body;
        body = {5'b0, MAGIC_NUMBER, (rd ? 8'h00 : data), addr, chip, 1'b1, rd};
        return {~^body, body};
    endfunction

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j]) begin
                if (!found_lo) begin
                    found_lo = 1'b1;
                    lo_idx   = j[IDW-1:0];
                end
                if (!found_hi && (j >= int'(ptr_q))) begin
                    found_hi = 1'b1;
                    hi_idx   = j[IDW-1:0];
                end
            end
        end
        win_sel = found_hi ? hi_idx : lo_idx;
    end

    assign win_nxt      = {1'b0, win_q} + 1'b1;
    assign ptr_inc      = (win_nxt == (IDW+1)'(NUM_REQ)) ? '0 : win_nxt[IDW-1:0];
    assign cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign rx_parity_ok = ((~^rx_data[62:0]) == rx_data[63]);
    assign rx_match     = rx_valid && rx_parity_ok && (rx_data[1:0] == 2'b11)
                          && (rx_data[17:10] == addr_q)
                          && ((rx_data[9:2] == chip_q) || (chip_q == GLOBAL_ID));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        rd_d        = rd_q;
        chip_d      = chip_q;
        addr_d      = addr_q;
        tx_data_d   = tx_data_q;
        ld_tx_data  = 1'b0;
        req_ack     = '0;
        rsp_valid   = 1'b0;
        rsp_id      = '0;
        rsp_data    = 8'h00;
        rsp_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((|req_valid) && !tx_busy) begin
                    win_d     = win_sel;
                    rd_d      = req_rd[win_sel];
                    chip_d    = req_chip_id[{win_sel, 3'b000} +: 8];
                    addr_d    = req_addr[{win_sel, 3'b000} +: 8];
                    tx_data_d = build_pkt(req_rd[win_sel], req_chip_id[{win_sel, 3'b000} +: 8],
                                          req_addr[{win_sel, 3'b000} +: 8],
                                          req_data[{win_sel, 3'b000} +: 8]);
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_tx_data = 1'b1;
                req_ack    = NUM_REQ'(1) << win_q;
                ptr_d      = ptr_inc;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = rd_q ? S_RD_WAIT : S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q >= GAP_LAST) state_d = S_IDLE;
                else                   cnt_d   = cnt_inc;
            end
            S_RD_WAIT: begin
                // A reply landing on the timeout cycle still counts as a match.
                if (rx_match) begin
                    rsp_valid = 1'b1;
                    rsp_id    = win_q;
                    rsp_data  = rx_data[25:18];
                    cnt_d     = '0;
                    state_d   = S_GAP;
                end else if (cnt_q == TMO_LAST) begin
                    rsp_valid   = 1'b1;
                    rsp_id      = win_q;
                    rsp_timeout = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
            rd_q      <= 1'b0;
            chip_q    <= 8'h00;
            addr_q    <= 8'h00;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            rd_q      <= rd_d;
            chip_q    <= chip_d;
            addr_q    <= addr_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign sched_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_larpix_cfg_scheduler.sv
// Bench for larpix_cfg_scheduler: directed scenarios plus randomized requests, checked
// against a packet/round-robin/timing reference model and a simple UART responder.
module tb_larpix_cfg_scheduler;

    localparam int          N     = 4;
    localparam int          GAP   = 4;
    localparam int          TMO   = 2000;
    localparam logic [31:0] MAGIC = 32'h89504E47;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_rd = '0;
    logic [8*N-1:0] req_chip_id = '0;
    logic [8*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ack;
    logic [63:0]    tx_data;
    logic           ld_tx_data;
    logic           tx_busy = 1'b0;
    logic           rx_valid = 1'b0;
    logic [63:0]    rx_data = '0;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_data;
    logic           rsp_timeout;
    logic           sched_busy;

    larpix_cfg_scheduler #(
        .NUM_REQ(N), .MAGIC_NUMBER(MAGIC), .GLOBAL_ID(8'd255),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_rd(req_rd),
        .req_chip_id(req_chip_id), .req_addr(req_addr), .req_data(req_data),
        .req_ack(req_ack), .tx_data(tx_data), .ld_tx_data(ld_tx_data), .tx_busy(tx_busy),
        .rx_valid(rx_valid), .rx_data(rx_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          rv [N];
    bit          rrd [N];
    logic [7:0]  rchip [N];
    logic [7:0]  raddr [N];
    logic [7:0]  rdata [N];
    logic [7:0]  rep_chip [2];
    logic [7:0]  rep_data [2];
    int          checks = 0;
    int          failures = 0;
    int          ptr_m = 0;
    int          last_mark = -1;
    int          last_win = 0;
    logic [63:0] last_pkt = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Packet assembled field by field; parity bit set when the rest has an even popcount.
    function automatic logic [63:0] make_pkt(input int op, input logic [7:0] chip,
                                             input logic [7:0] addr, input logic [7:0] data);
        logic [63:0] p;
        p = (64'(MAGIC) << 26) | 64'(op) | (64'(chip) << 2) | (64'(addr) << 10) | (64'(data) << 18);
        if ($countones(p) % 2 == 0) p = p | (64'h1 << 63);
        return p;
    endfunction

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (rv[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    function automatic bit any_req();
        for (int i = 0; i < N; i++) if (rv[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = rv[i];
            req_rd[i]            = rrd[i];
            req_chip_id[8*i +: 8] = rchip[i];
            req_addr[8*i +: 8]    = raddr[i];
            req_data[8*i +: 8]    = rdata[i];
        end
    endtask

    task automatic set_req(input int i, input bit rd, input logic [7:0] chip,
                           input logic [7:0] addr, input logic [7:0] data);
        rv[i] = 1'b1; rrd[i] = rd; rchip[i] = chip; raddr[i] = addr; rdata[i] = data;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 8'($urandom), 8'($urandom));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset_n = 1'b0; tx_busy = 1'b0; rx_valid = 1'b0; rx_data = '0;
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        drive_reqs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ptr_m = 0;
        last_mark = -1;
    endtask

    task automatic wait_ld(output bit ok, output int stray);
        ok = 1'b0;
        stray = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (rsp_valid) stray++;
            if (ld_tx_data) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic rx_inject(input logic [63:0] pkt, input bit hit, input int id,
                             input logic [7:0] data, input string tag);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = pkt;
        #1;
        check({tag, "_rsp_valid"}, rsp_valid, hit);
        if (hit) begin
            last_mark = cyc;
            check({tag, "_rsp_id"}, rsp_id, id);
            check({tag, "_rsp_data"}, rsp_data, data);
            check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    // mode: 0 reply (optionally preceded by junk kind), 1 no reply, 2 two broadcast replies,
    // 3 reply on the final timeout cycle. after: 0 drop, 1 keep, 2 random new request.
    task automatic serve(input int mode, input int junk, input int after, input bit check_gap);
        int          exp_w, stray, t, jk;
        bit          ok, is_rd;
        logic [7:0]  chip, addr, rc;
        logic [63:0] exp_pkt, jpkt;
        exp_w = model_winner();
        wait_ld(ok, stray);
        check("ld_seen", ok, 1);
        if (!ok || exp_w < 0) return;
        check("stray_rsp", stray, 0);
        if (check_gap && last_mark >= 0) check("gap_clocks", cyc - last_mark, GAP + 2);
        is_rd   = rrd[exp_w];
        chip    = rchip[exp_w];
        addr    = raddr[exp_w];
        exp_pkt = make_pkt(is_rd ? 3 : 2, chip, addr, is_rd ? 8'h00 : rdata[exp_w]);
        check("req_ack", req_ack, 64'(1) << exp_w);
        check("tx_data", tx_data, exp_pkt);
        check("parity_odd", $countones(tx_data) % 2, 1);
        last_pkt = tx_data;
        last_win = exp_w;
        ptr_m = (exp_w + 1) % N;
        if (after == 0) rv[exp_w] = 1'b0;
        else if (after == 2) begin
            if ($urandom_range(0, 1) == 1) rand_req(exp_w);
            else rv[exp_w] = 1'b0;
        end
        drive_reqs();
        repeat ($urandom_range(1, 3)) @(negedge clk);
        tx_busy = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        check("tx_hold", tx_data, exp_pkt);
        tx_busy = 1'b0;
        last_mark = cyc;
        if (!is_rd) return;
        rc = (chip == 8'd255) ? rep_chip[0] : chip;
        case (mode)
            0: begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                jk = (junk == 3 && chip == 8'd255) ? 0 : junk;
                if (jk >= 0) begin
                    case (jk)
                        0:       jpkt = make_pkt(3, rc, addr ^ 8'h5A, rep_data[0]);
                        1:       jpkt = make_pkt(2, rc, addr, rep_data[0]);
                        2:       jpkt = make_pkt(3, rc, addr, rep_data[0]) ^ (64'h1 << 63);
                        default: jpkt = make_pkt(3, chip ^ 8'h01, addr, rep_data[0]);
                    endcase
                    rx_inject(jpkt, 1'b0, 0, 8'h00, "junk");
                end
                rx_inject(make_pkt(3, rc, addr, rep_data[0]), 1'b1, exp_w, rep_data[0], "reply");
                #1 check("rsp_single", rsp_valid, 0);
            end
            1: begin
                t = 0;
                while (t < TMO + 20) begin
                    @(negedge clk);
                    t++;
                    if (rsp_valid) break;
                end
                last_mark = cyc;
                check("timeout_clocks", t, TMO);
                check("timeout_flag", rsp_timeout, 1);
                check("timeout_data", rsp_data, 0);
                check("timeout_id", rsp_id, exp_w);
                @(negedge clk);
                check("timeout_single", rsp_valid, 0);
            end
            2: begin
                rx_inject(make_pkt(3, rep_chip[0], addr, rep_data[0]), 1'b1, exp_w, rep_data[0], "bcast1");
                rx_inject(make_pkt(3, rep_chip[1], addr, rep_data[1]), 1'b0, 0, 8'h00, "bcast2");
            end
            default: begin
                repeat (TMO - 1) @(negedge clk);
                check("edge_no_early_rsp", rsp_valid, 0);
                rx_inject(make_pkt(3, rc, addr, rep_data[0]), 1'b1, exp_w, rep_data[0], "edge");
            end
        endcase
    endtask

    initial begin
        bit ok;
        int stray;
        bit pend;
        for (int i = 0; i < N; i++) begin
            rv[i] = 0; rrd[i] = 0; rchip[i] = 0; raddr[i] = 0; rdata[i] = 0;
        end

        // Reset state
        @(negedge clk);
        check("rst_tx_data", tx_data, 0);
        check("rst_ld", ld_tx_data, 0);
        check("rst_ack", req_ack, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_busy", sched_busy, 0);
        reset_n = 1'b1;

        // Single write from requester 0
        set_req(0, 1'b0, 8'h10, 8'h05, 8'hA5);
        drive_reqs();
        serve(0, -1, 0, 1'b0);
        check("t1_low_fields", last_pkt[25:0], {8'hA5, 8'h05, 8'h10, 2'b10});
        check("t1_magic", last_pkt[57:26], 32'h89504E47);

        // All four requesters continuously valid: strict rotation with gaps
        reset_dut();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'($urandom_range(0, 254)), 8'($urandom), 8'($urandom));
        drive_reqs();
        for (int k = 0; k < 6; k++) begin
            serve(0, -1, 1, k > 0);
            check("rr_order", last_win, k % N);
        end
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        drive_reqs();

        // Read from requester 2 with a wrong-address reply first
        set_req(2, 1'b1, 8'h1F, 8'h10, 8'h00);
        drive_reqs();
        rep_data[0] = 8'h3C;
        serve(0, 0, 0, 1'b0);

        // Read with no reply, then a write that must follow after the gap
        set_req(3, 1'b1, 8'h40, 8'h07, 8'h00);
        drive_reqs();
        serve(1, -1, 0, 1'b0);
        set_req(0, 1'b0, 8'h21, 8'h0C, 8'h9E);
        drive_reqs();
        serve(0, -1, 0, 1'b1);

        // Broadcast read: first reply wins, second ignored
        set_req(1, 1'b1, 8'd255, 8'h44, 8'h00);
        drive_reqs();
        rep_chip[0] = 8'd0;  rep_data[0] = 8'h11;
        rep_chip[1] = 8'd16; rep_data[1] = 8'h22;
        serve(2, -1, 0, 1'b0);

        // Reply arriving on the timeout cycle resolves as a match
        set_req(0, 1'b1, 8'h05, 8'h06, 8'h00);
        drive_reqs();
        rep_data[0] = 8'h77;
        serve(3, -1, 0, 1'b0);

        // Reset during WAIT_DONE of a read; the request is re-granted afterwards
        reset_dut();
        set_req(1, 1'b1, 8'h22, 8'h33, 8'h00);
        drive_reqs();
        wait_ld(ok, stray);
        check("rr_ld_seen", ok, 1);
        check("rr_ack", req_ack, 4'b0010);
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        check("rr_busy_before", sched_busy, 1);
        reset_n = 1'b0;
        #1;
        check("rr_ld", ld_tx_data, 0);
        check("rr_ack_zero", req_ack, 0);
        check("rr_tx_data", tx_data, 0);
        check("rr_rsp_valid", rsp_valid, 0);
        check("rr_sched_busy", sched_busy, 0);
        @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ptr_m = 0;
        last_mark = -1;
        rep_data[0] = 8'h5E;
        serve(0, 2, 0, 1'b0);

        // Randomized traffic
        for (int r = 0; r < 16; r++) begin
            pend = any_req();
            if (!pend) begin
                rand_req(int'($urandom_range(0, N - 1)));
                drive_reqs();
            end
            rep_data[0] = 8'($urandom);
            serve(0, int'($urandom_range(0, 4)) - 1, 2, pend);
        end
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        drive_reqs();

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
